mem_stage_lsu: RTL

//  MEM-stage load/store unit of the RV32I 5-stage pipeline; sits between EX/MEM and MEM/WB registers.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/mem_stage_lsu_if.sv | 22 ++
 rtl/mem_stage_lsu_load_formatter.sv | 32 +++
 rtl/mem_stage_lsu.sv | 115 +++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the MEM-stage LSU state type.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // True when the access cannot be issued: unsupported funct3 or misaligned address.
    function automatic logic access_err(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad_f3;
        bad_f3 = is_store ? !(f3 inside {F3_SB, F3_SH, F3_SW})
                          : !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        return bad_f3 | ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/acknowledge data-memory bus between the MEM-stage LSU and data memory.
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_formatter.sv
// Extracts the addressed byte/half/word from a read word and sign/zero-extends it.
module load_formatter
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{offset, 3'b000} +: 8];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every path assigns result, so no latch is inferred.
        result = '0;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   result = rdata;
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/ack memory transaction per load/store
// and stalls the pipeline until the formatted result is available.
module mem_stage_lsu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_enM,
    input  logic                   mem_weM,
    input  logic [2:0]             funct3M,
    input  logic [XLEN-1:0]        resultM,
    input  logic [XLEN-1:0]        wdM,
    output logic [XLEN-1:0]        dm_rdM,
    output logic                   stallM,
    output logic                   errM,
    mem_stage_lsu_if.master        dmem
);

    lsu_state_t      state, state_n;
    logic            req_q, we_q, is_store_q;
    logic [XLEN-1:0] addr_q, wdata_q, dm_rd_q, fmt_data;
    logic [3:0]      be_q, be_n;
    logic [XLEN-1:0] wdata_n;
    logic [1:0]      offset_q;
    logic [2:0]      funct3_q;
    logic            issue;

    assign errM   = mem_enM & access_err(mem_weM, funct3M, resultM[1:0]);
    assign issue  = mem_enM & ~errM;
    assign stallM = issue & (state != DONE);
    assign dm_rdM = (state == DONE) ? dm_rd_q : '0;

    // Store lane steering: replicate data across lanes, enable only the addressed ones.
    always_comb begin
        be_n    = 4'b0000;
        wdata_n = wdM;
        case (funct3M)
            F3_SB: begin
                be_n    = 4'b0001 << resultM[1:0];
                wdata_n = {4{wdM[7:0]}};
            end
            F3_SH: begin
                be_n    = resultM[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wdM[15:0]}};
            end
            F3_SW:   be_n = 4'b1111;
            default: be_n = 4'b0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (issue) state_n = WAIT;
            WAIT:    if (dmem.dmem_ack) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            offset_q   <= 2'b00;
            funct3_q   <= 3'b000;
            dm_rd_q    <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    req_q      <= 1'b1;
                    we_q       <= mem_weM;
                    is_store_q <= mem_weM;
                    addr_q     <= {resultM[XLEN-1:2], 2'b00};
                    be_q       <= mem_weM ? be_n : 4'b0000;
                    wdata_q    <= wdata_n;
                    offset_q   <= resultM[1:0];
                    funct3_q   <= funct3M;
                end
                WAIT: if (dmem.dmem_ack) begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    dm_rd_q <= is_store_q ? '0 : fmt_data;
                end
                default: ;
            endcase
        end
    end

    load_formatter #(.XLEN(XLEN)) u_load_formatter (
        .rdata  (dmem.dmem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (fmt_data)
    );

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule
